// File: rtl/iscas_seqctl.sv
// Sequence controller: terminal step counter, loop counter, IDLE/RUN/HOLD/DONE FSM
// and a bank of toggle flops, all sharing one synchronous clear. Every output is a flop.
module iscas_seqctl #(
  parameter int CNT_W  = 4,
  parameter int TERM   = 2**CNT_W-1,
  parameter int LOOPS  = 3,
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              start,
  input  logic              hold,
  input  logic [NUM_CH-1:0] tog,
  output logic [CNT_W-1:0]  cnt,
  output logic [1:0]        state,
  output logic [NUM_CH-1:0] tog_q,
  output logic              wrap,
  output logic              done
);

  localparam int LW = $clog2(LOOPS+1);
  localparam logic [CNT_W-1:0] TERM_C  = CNT_W'(TERM);
  localparam logic [LW-1:0]    LOOPS_C = LW'(LOOPS);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]       loop_q, loop_d, loop_inc;
  logic [NUM_CH-1:0]   tog_d;
  logic                wrap_d, done_d;

  assign loop_inc = loop_q + LW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loop_d  = loop_q;
    wrap_d  = 1'b0;
    tog_d   = tog_q ^ tog;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        loop_d = '0;
        if (start) state_d = RUN;
      end
      RUN: begin
        // hold takes precedence over a pending wrap; cnt stays at TERM until release
        if (hold) begin
          state_d = HOLD;
        end else if (cnt_q != TERM_C) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d  = '0;
          wrap_d = 1'b1;
          loop_d = loop_inc;
          if (loop_inc == LOOPS_C) state_d = DONE;
        end
      end
      HOLD: begin
        if (!hold) state_d = RUN;
      end
      DONE: begin
        cnt_d = '0;
        if (start) begin
          state_d = RUN;
          loop_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      loop_d  = '0;
      wrap_d  = 1'b0;
      tog_d   = '0;
    end
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      loop_q  <= '0;
      tog_q   <= '0;
      wrap    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loop_q  <= loop_d;
      tog_q   <= tog_d;
      wrap    <= wrap_d;
      done    <= done_d;
    end
  end

  assign cnt   = cnt_q;
  assign state = state_q;

endmodule
